// File: rtl/feed_rc4.sv
// feed_rc4: writes a 64-bit word as 16 nibbles into the RC4 nibble scratch
// memory, then optionally reads every location back and flags the first
// location whose contents differ from the nibble that was written.
module feed_rc4 #(
  parameter int NIB_W = 4,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NIB_W*DEPTH-1:0] data_in,
  input  logic                   verify_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [AW-1:0]          bad_addr,
  output logic [AW-1:0]          addi,
  output logic [NIB_W-1:0]       in,
  output logic                   wr_1,
  output logic [AW-1:0]          addo,
  output logic                   rd_1,
  input  logic [NIB_W-1:0]       out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [NIB_W*DEPTH-1:0] data_q, data_d;
  logic                   verify_q, verify_d;
  logic                   err_q, err_d;
  logic [AW-1:0]          bad_addr_q, bad_addr_d;

  logic [NIB_W-1:0]       nib [DEPTH];
  logic [AW-1:0]          prev_idx;
  logic                   idx_last;
  logic                   cmp_valid;

  // Address 0 holds the most significant nibble of the latched word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_nib
    assign nib[gi] = data_q[NIB_W*(DEPTH-gi)-1 -: NIB_W];
  end

  // Read data arriving this cycle belongs to the address issued last cycle.
  assign prev_idx = idx_q - {{(AW-1){1'b0}}, 1'b1};
  assign idx_last = (idx_q == AW'(DEPTH-1));

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Next-state, index sequencing and first-mismatch capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    verify_d   = verify_q;
    err_d      = err_q;
    bad_addr_d = bad_addr_q;
    cmp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d     = data_in;
          verify_d   = verify_en;
          err_d      = 1'b0;
          bad_addr_d = '0;
          idx_d      = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_last ? '0 : idx_q + {{(AW-1){1'b0}}, 1'b1};
        if (idx_last) begin
          state_d = verify_q ? READ : DONE;
        end
      end
      READ: begin
        idx_d     = idx_last ? '0 : idx_q + {{(AW-1){1'b0}}, 1'b1};
        cmp_valid = (idx_q != '0);
        if (idx_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // idx has wrapped to 0, so prev_idx points at the last address.
        cmp_valid = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cmp_valid && !err_q && (out != nib[prev_idx])) begin
      err_d      = 1'b1;
      bad_addr_d = prev_idx;
    end
  end

  // Memory port and status outputs decode straight from the state register.
  assign busy     = (state_q == WRITE) || (state_q == READ) || (state_q == FLUSH);
  assign done     = (state_q == DONE);
  assign wr_1     = (state_q == WRITE);
  assign rd_1     = (state_q == READ);
  assign addi     = wr_1 ? idx_q : '0;
  assign in       = wr_1 ? nib[idx_q] : '0;
  assign addo     = rd_1 ? idx_q : '0;
  assign err      = err_q;
  assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_feed_rc4.sv
// Bench for feed_rc4: memory model with fault injection, cycle-exact port
// expectations derived from the operation timeline, table plus random ops.
module tb_feed_rc4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] data_in;
  logic        verify_en;
  logic        busy, done, err, wr_1, rd_1;
  logic [3:0]  bad_addr, addi, addo, mem_in;
  logic [3:0]  mem_out;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  feed_rc4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .verify_en(verify_en), .busy(busy), .done(done), .err(err),
    .bad_addr(bad_addr), .addi(addi), .in(mem_in), .wr_1(wr_1),
    .addo(addo), .rd_1(rd_1), .out(mem_out)
  );

  // Scratch memory: writes are XORed with a per-address fault mask.
  logic [3:0]  mem [16];
  logic [63:0] xmask_r = '0;
  always @(posedge clk) begin
    if (wr_1 && !rd_1) mem[addi] <= mem_in ^ xmask_r[63-4*int'(addi) -: 4];
    if (rd_1 && !wr_1) mem_out <= mem[addo];
  end

  function automatic logic [3:0] nib_of(input logic [63:0] w, input int i);
    return w[63-4*i -: 4];
  endfunction

  function automatic logic [63:0] mem_word();
    logic [63:0] w;
    for (int i = 0; i < 16; i++) w[63-4*i -: 4] = mem[i];
    return w;
  endfunction

  // Reference: first address whose stored nibble differs from the written one.
  task automatic model_err(input logic [63:0] d, input logic v, input logic [63:0] xm,
                           output logic e, output logic [3:0] b);
    e = 1'b0;
    b = 4'd0;
    if (v) begin
      for (int i = 0; i < 16; i++) begin
        if (!e && ((nib_of(d, i) ^ nib_of(xm, i)) != nib_of(d, i))) begin
          e = 1'b1;
          b = 4'(i);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Checks every cycle after acceptance edge E0 until the done cycle.
  task automatic run_body(input logic [63:0] d, input logic v, input logic [63:0] xm,
                          input logic exp_e, input logic [3:0] exp_b, input bit inject,
                          input bit chain, input logic [63:0] nd, input logic nv);
    int n;
    logic [14:0] act, exp;
    logic        e_busy, e_wr, e_rd;
    logic [3:0]  e_addi, e_in, e_addo;
    n = v ? 34 : 17;
    xmask_r = xm;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e_wr   = (c <= 16);
      e_rd   = v && (c >= 17) && (c <= 32);
      e_busy = (c <= 16) || (v && c <= 33);
      e_addi = e_wr ? 4'(c-1) : 4'd0;
      e_in   = e_wr ? nib_of(d, c-1) : 4'd0;
      e_addo = e_rd ? 4'(c-17) : 4'd0;
      exp = {e_busy, (c == n), e_wr, e_addi, e_in, e_rd, e_addo};
      act = {busy, done, wr_1, addi, mem_in, rd_1, addo};
      chk($sformatf("cycle%0d {busy,done,wr,addi,in,rd,addo}", c), 64'(act), 64'(exp));
      if (c == 1) begin
        start   = 1'b0;
        data_in = {$urandom, $urandom};
      end
      if (inject && (c == 5 || (v && c == 20))) begin
        start   = 1'b1;
        data_in = ~d;
      end
      if (inject && (c == 6 || (v && c == 21))) start = 1'b0;
      if (c == n) begin
        chk("err_at_done", 64'(err), 64'(exp_e));
        if (exp_e) chk("bad_addr_at_done", 64'(bad_addr), 64'(exp_b));
        chk("mem_contents", mem_word(), d ^ xm);
        if (chain) begin
          start = 1'b1;
          data_in = nd;
          verify_en = nv;
        end
      end
    end
    $display("op data=%h verify=%0d xmask=%h err=%0d bad_addr=%0d", d, v, xm, err, bad_addr);
  endtask

  task automatic idle_check(input logic e, input logic [3:0] b);
    @(negedge clk);
    chk("idle {busy,done,wr,rd}", 64'({busy, done, wr_1, rd_1}), 64'(0));
    chk("idle err hold", 64'({err, (e ? bad_addr : 4'd0)}), 64'({e, b}));
  endtask

  task automatic op(input logic [63:0] d, input logic v, input logic [63:0] xm,
                    input logic e, input logic [3:0] b, input bit inject);
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    verify_en = v;
    @(posedge clk);
    run_body(d, v, xm, e, b, inject, 1'b0, '0, 1'b0);
    idle_check(e, b);
  endtask

  typedef struct {
    logic [63:0] data;
    logic        v;
    logic [63:0] xm;
    logic        exp_err;
    logic [3:0]  exp_bad;
    bit          inject;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [63:0] d, xm;
    logic        v, e;
    logic [3:0]  b;

    tbl.push_back('{64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{64'h0123_4567_89AB_CDEF, 1'b1, 64'h0000_0F00_0F00_0000, 1'b1, 4'd5, 1'b0});
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 4'd15, 1'b0});
    tbl.push_back('{64'h0000_0000_0000_0000, 1'b1, 64'h1000_0000_0000_0000, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 1'b0, 4'd0, 1'b1});
    tbl.push_back('{64'h5A5A_A5A5_3C3C_C3C3, 1'b1, 64'h0, 1'b0, 4'd0, 1'b1});

    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;
    verify_en = 1'b0;
    #2;
    chk("reset outputs", 64'({busy, done, err, wr_1, rd_1, bad_addr, addi, mem_in, addo}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) op(tbl[i].data, tbl[i].v, tbl[i].xm, tbl[i].exp_err, tbl[i].exp_bad, tbl[i].inject);

    // Random operations against the reference model.
    for (int r = 0; r < 10; r++) begin
      d = {$urandom, $urandom};
      v = 1'($urandom_range(0, 1));
      xm = '0;
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 7) == 0) xm[63-4*i -: 4] = 4'($urandom_range(1, 15));
      model_err(d, v, xm, e, b);
      op(d, v, xm, e, b, 1'($urandom_range(0, 1)));
    end

    // Reset in cycle 8 of WRITE after an op that left err set.
    op(64'h0123_4567_89AB_CDEF, 1'b1, 64'h0000_0F00_0F00_0000, 1'b1, 4'd5, 1'b0);
    @(negedge clk);
    start = 1'b1;
    data_in = 64'h1111_2222_3333_4444;
    verify_en = 1'b1;
    @(posedge clk);
    xmask_r = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("wr_1 before reset", 64'(wr_1), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, err, wr_1, rd_1, bad_addr, addi, mem_in, addo}), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no done in reset", 64'({done, busy, wr_1}), 64'(0));
    end
    rst_n = 1'b1;
    $display("op reset asserted mid-write");
    op(64'h0F1E_2D3C_4B5A_6978, 1'b1, 64'h0, 1'b0, 4'd0, 1'b0);

    // Back-to-back: second start held high through DONE.
    @(negedge clk);
    start = 1'b1;
    data_in = 64'h8765_4321_FEDC_BA98;
    verify_en = 1'b0;
    @(posedge clk);
    run_body(64'h8765_4321_FEDC_BA98, 1'b0, 64'h0, 1'b0, 4'd0, 1'b0,
             1'b1, 64'hA1B2_C3D4_E5F6_0718, 1'b1);
    idle_check(1'b0, 4'd0);
    @(posedge clk);
    run_body(64'hA1B2_C3D4_E5F6_0718, 1'b1, 64'h0000_0000_00F0_0000, 1'b1, 4'd10,
             1'b0, 1'b0, '0, 1'b0);
    idle_check(1'b1, 4'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
